// File: rtl/watch.sv
// -----------------------------------------------------------------------------
// watch -- 24-hour BCD time-of-day counter (HH:MM:SS)
//
// Keeps time as six BCD digits. While `set` is high, the counter loads the
// six input digits on each rising edge, but only when they form a legal time
// of day. While `set` is low, a prescaler divides clk down to a one-second
// tick, and each tick advances the time by one second with a BCD carry chain.
// Every output is a register value; no combinational path runs from the
// inputs to the outputs.
//
// Parameters:
//   TICKS_PER_SEC  clock edges per one-second advance (1 = every edge)
//
// Ports:
//   clk            system clock, all state changes on the rising edge
//   rst_n          synchronous active-low reset (time 00:00:00, prescaler 0)
//   sec_in_lsb     BCD seconds units to load (0-9)
//   sec_in_msb     BCD seconds tens to load (0-5)
//   min_in_lsb     BCD minutes units to load (0-9)
//   min_in_msb     BCD minutes tens to load (0-5)
//   hr_in_lsb      BCD hours units to load (0-9, 0-3 when tens = 2)
//   hr_in_msb      BCD hours tens to load (0-2)
//   set            level-sensitive load enable, active-high
//   sec_out_lsb    current seconds units
//   sec_out_msb    current seconds tens
//   min_out_lsb    current minutes units
//   min_out_msb    current minutes tens
//   hr_out_lsb     current hours units
//   hr_out_msb     current hours tens
// -----------------------------------------------------------------------------
module watch #(
  parameter int unsigned TICKS_PER_SEC = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] sec_in_lsb,
  input  logic [3:0] sec_in_msb,
  input  logic [3:0] min_in_lsb,
  input  logic [3:0] min_in_msb,
  input  logic [3:0] hr_in_lsb,
  input  logic [3:0] hr_in_msb,
  input  logic       set,
  output logic [3:0] sec_out_lsb,
  output logic [3:0] sec_out_msb,
  output logic [3:0] min_out_lsb,
  output logic [3:0] min_out_msb,
  output logic [3:0] hr_out_lsb,
  output logic [3:0] hr_out_msb
);

  // A one-bit prescaler is kept even for TICKS_PER_SEC = 1 so the width never
  // collapses to zero; its terminal count is then 0 and it never moves.
  localparam int unsigned PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PRESC_TC  = PW'(TICKS_PER_SEC - 1);
  localparam logic [PW-1:0] PRESC_ONE = PW'(1);

  logic [PW-1:0] presc_q, presc_d;
  logic [3:0]    sec_lsb_q, sec_lsb_d;
  logic [3:0]    sec_msb_q, sec_msb_d;
  logic [3:0]    min_lsb_q, min_lsb_d;
  logic [3:0]    min_msb_q, min_msb_d;
  logic [3:0]    hr_lsb_q,  hr_lsb_d;
  logic [3:0]    hr_msb_q,  hr_msb_d;

  logic          load_valid;
  logic          tick;

  // Legal time-of-day check on the load digits.
  function automatic logic time_is_valid(
    input logic [3:0] s_lsb, input logic [3:0] s_msb,
    input logic [3:0] m_lsb, input logic [3:0] m_msb,
    input logic [3:0] h_lsb, input logic [3:0] h_msb
  );
    logic ok;
    ok = (s_lsb <= 4'd9) && (s_msb <= 4'd5) &&
         (m_lsb <= 4'd9) && (m_msb <= 4'd5) &&
         (h_lsb <= 4'd9) && (h_msb <= 4'd2);
    // Twenty-something hours only run up to 23.
    if ((h_msb == 4'd2) && (h_lsb > 4'd3)) begin
      ok = 1'b0;
    end else begin
      ok = ok;
    end
    return ok;
  endfunction

  assign load_valid = time_is_valid(sec_in_lsb, sec_in_msb, min_in_lsb,
                                    min_in_msb, hr_in_lsb, hr_in_msb);
  assign tick       = (presc_q == PRESC_TC);

  // Next-state: load takes priority over counting; counting runs the carry chain.
  always_comb begin
    presc_d   = presc_q;
    sec_lsb_d = sec_lsb_q;
    sec_msb_d = sec_msb_q;
    min_lsb_d = min_lsb_q;
    min_msb_d = min_msb_q;
    hr_lsb_d  = hr_lsb_q;
    hr_msb_d  = hr_msb_q;

    if (set) begin
      // Prescaler restarts on any load attempt, legal or not.
      presc_d = '0;
      if (load_valid) begin
        sec_lsb_d = sec_in_lsb;
        sec_msb_d = sec_in_msb;
        min_lsb_d = min_in_lsb;
        min_msb_d = min_in_msb;
        hr_lsb_d  = hr_in_lsb;
        hr_msb_d  = hr_in_msb;
      end else begin
        sec_lsb_d = sec_lsb_q;
      end
    end else if (tick) begin
      presc_d = '0;
      if (sec_lsb_q != 4'd9) begin
        sec_lsb_d = sec_lsb_q + 4'd1;
      end else begin
        sec_lsb_d = 4'd0;
        if (sec_msb_q != 4'd5) begin
          sec_msb_d = sec_msb_q + 4'd1;
        end else begin
          sec_msb_d = 4'd0;
          if (min_lsb_q != 4'd9) begin
            min_lsb_d = min_lsb_q + 4'd1;
          end else begin
            min_lsb_d = 4'd0;
            if (min_msb_q != 4'd5) begin
              min_msb_d = min_msb_q + 4'd1;
            end else begin
              min_msb_d = 4'd0;
              // Hour digits: 23 wraps to 00, x9 carries into the tens.
              if ((hr_msb_q == 4'd2) && (hr_lsb_q == 4'd3)) begin
                hr_msb_d = 4'd0;
                hr_lsb_d = 4'd0;
              end else if (hr_lsb_q == 4'd9) begin
                hr_lsb_d = 4'd0;
                hr_msb_d = hr_msb_q + 4'd1;
              end else begin
                hr_lsb_d = hr_lsb_q + 4'd1;
              end
            end
          end
        end
      end
    end else begin
      presc_d = presc_q + PRESC_ONE;
    end
  end

  // State registers with synchronous active-low reset to 00:00:00.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc_q   <= '0;
      sec_lsb_q <= 4'd0;
      sec_msb_q <= 4'd0;
      min_lsb_q <= 4'd0;
      min_msb_q <= 4'd0;
      hr_lsb_q  <= 4'd0;
      hr_msb_q  <= 4'd0;
    end else begin
      presc_q   <= presc_d;
      sec_lsb_q <= sec_lsb_d;
      sec_msb_q <= sec_msb_d;
      min_lsb_q <= min_lsb_d;
      min_msb_q <= min_msb_d;
      hr_lsb_q  <= hr_lsb_d;
      hr_msb_q  <= hr_msb_d;
    end
  end

  assign sec_out_lsb = sec_lsb_q;
  assign sec_out_msb = sec_msb_q;
  assign min_out_lsb = min_lsb_q;
  assign min_out_msb = min_msb_q;
  assign hr_out_lsb  = hr_lsb_q;
  assign hr_out_msb  = hr_msb_q;

endmodule

// File: tb/tb_watch.sv
// -----------------------------------------------------------------------------
// tb_watch -- self-checking bench for watch
//
// Two instances share the stimulus: one advancing every edge, one every
// fourth edge. A reference model keeps time as seconds-since-midnight plus a
// plain edge counter, and is compared with both instances after every edge.
// Directed sequences add fixed expected times; a random phase follows.
// -----------------------------------------------------------------------------
module tb_watch;

  logic       clk;
  logic       rst_n;
  logic       set;
  logic [3:0] sec_in_lsb, sec_in_msb, min_in_lsb, min_in_msb, hr_in_lsb, hr_in_msb;

  logic [3:0] a_sl, a_sm, a_ml, a_mm, a_hl, a_hm;
  logic [3:0] b_sl, b_sm, b_ml, b_mm, b_hl, b_hm;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: seconds since midnight and edges since last second/load.
  int t1 = 0, p1 = 0;
  int t4 = 0, p4 = 0;

  watch #(.TICKS_PER_SEC(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .sec_in_lsb(sec_in_lsb), .sec_in_msb(sec_in_msb),
    .min_in_lsb(min_in_lsb), .min_in_msb(min_in_msb),
    .hr_in_lsb(hr_in_lsb), .hr_in_msb(hr_in_msb),
    .set(set),
    .sec_out_lsb(a_sl), .sec_out_msb(a_sm),
    .min_out_lsb(a_ml), .min_out_msb(a_mm),
    .hr_out_lsb(a_hl), .hr_out_msb(a_hm)
  );

  watch #(.TICKS_PER_SEC(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .sec_in_lsb(sec_in_lsb), .sec_in_msb(sec_in_msb),
    .min_in_lsb(min_in_lsb), .min_in_msb(min_in_msb),
    .hr_in_lsb(hr_in_lsb), .hr_in_msb(hr_in_msb),
    .set(set),
    .sec_out_lsb(b_sl), .sec_out_msb(b_sm),
    .min_out_lsb(b_ml), .min_out_msb(b_mm),
    .hr_out_lsb(b_hl), .hr_out_msb(b_hm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [23:0] obs1();
    return {a_hm, a_hl, a_mm, a_ml, a_sm, a_sl};
  endfunction

  function automatic logic [23:0] obs4();
    return {b_hm, b_hl, b_mm, b_ml, b_sm, b_sl};
  endfunction

  // Seconds-since-midnight to packed HHMMSS BCD.
  function automatic logic [23:0] to_bcd(input int t);
    int h, m, s;
    h = t / 3600;
    m = (t / 60) % 60;
    s = t % 60;
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  task automatic check(input string tag, input logic [23:0] got, input logic [23:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [23:0] d);
    {hr_in_msb, hr_in_lsb, min_in_msb, min_in_lsb, sec_in_msb, sec_in_lsb} = d;
  endtask

  // Apply the rules for one rising edge to one model instance.
  task automatic model_edge(input int tps, inout int t, inout int p);
    int s0, s1, m0, m1, h0, h1;
    s0 = int'(sec_in_lsb); s1 = int'(sec_in_msb);
    m0 = int'(min_in_lsb); m1 = int'(min_in_msb);
    h0 = int'(hr_in_lsb);  h1 = int'(hr_in_msb);
    if (!rst_n) begin
      t = 0; p = 0;
    end else if (set) begin
      p = 0;
      if (s0 <= 9 && s1 <= 5 && m0 <= 9 && m1 <= 5 && h0 <= 9 && h1 <= 2 &&
          (h1 * 10 + h0) <= 23)
        t = (h1 * 10 + h0) * 3600 + (m1 * 10 + m0) * 60 + (s1 * 10 + s0);
    end else begin
      p = p + 1;
      if (p == tps) begin
        p = 0;
        t = (t + 1) % 86400;
      end
    end
  endtask

  // One clock edge: update the model, then compare both instances on the falling edge.
  task automatic step();
    @(posedge clk);
    model_edge(1, t1, p1);
    model_edge(4, t4, p4);
    @(negedge clk);
    check("model_t1", obs1(), to_bcd(t1));
    check("model_t4", obs4(), to_bcd(t4));
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic load_pulse(input logic [23:0] d);
    drive(d);
    set = 1'b1;
    step();
    set = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    set   = 1'b0;
    drive(24'h000000);

    // Reset state.
    steps(2);
    check("reset_t1", obs1(), 24'h000000);
    check("reset_t4", obs4(), 24'h000000);

    // First advance after release.
    rst_n = 1'b1;
    step();
    check("first_t1", obs1(), 24'h000001);
    check("first_t4_early", obs4(), 24'h000000);
    steps(3);
    check("first_t4", obs4(), 24'h000001);

    // Reset held for two edges mid-count.
    steps(7);
    rst_n = 1'b0;
    steps(2);
    check("midreset_t1", obs1(), 24'h000000);
    check("midreset_t4", obs4(), 24'h000000);
    rst_n = 1'b1;
    step();
    check("postreset_t1", obs1(), 24'h000001);

    // Seconds rollover.
    load_pulse(24'h034553);
    check("load_t1", obs1(), 24'h034553);
    check("load_t4", obs4(), 24'h034553);
    steps(6);
    check("sec59", obs1(), 24'h034559);
    step();
    check("sec_roll", obs1(), 24'h034600);

    // Minute and hour rollovers.
    load_pulse(24'h065955);
    steps(5);
    check("min_roll", obs1(), 24'h070000);
    load_pulse(24'h095959);
    step();
    check("hr_9_10", obs1(), 24'h100000);
    load_pulse(24'h195959);
    step();
    check("hr_19_20", obs1(), 24'h200000);

    // Day rollover.
    load_pulse(24'h235955);
    steps(5);
    check("day_roll", obs1(), 24'h000000);
    step();
    check("day_roll_next", obs1(), 24'h000001);

    // Frozen time while set is held.
    drive(24'h065855);
    set = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check("frozen", obs1(), 24'h065855);
    end
    set = 1'b0;
    step();
    check("unfreeze", obs1(), 24'h065856);

    // Invalid loads are ignored but restart the prescaler.
    load_pulse(24'h120000);
    load_pulse(24'h240000);
    check("inv_hr_t1", obs1(), 24'h120000);
    check("inv_hr_t4", obs4(), 24'h120000);
    steps(3);
    check("inv_t4_wait", obs4(), 24'h120000);
    step();
    check("inv_t1_run", obs1(), 24'h120004);
    check("inv_t4_adv", obs4(), 24'h120001);
    load_pulse(24'h120060);
    check("inv_sec_t1", obs1(), 24'h120004);
    step();
    check("inv_sec_next", obs1(), 24'h120005);

    // Random phase.
    for (int i = 0; i < 3000; i++) begin
      rst_n = ($urandom_range(0, 63) != 0);
      set   = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 1) == 0)
        drive(to_bcd(int'($urandom_range(0, 86399))));
      else
        drive(24'($urandom()));
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
